// File: rtl/silent_lpf_sequencer.sv
// Purpose: sequences the silent LPF, turning divided timer ticks or software requests into single-cycle LPF_UPDATE pulses.
// Latency: request in cycle N gives LPF_UPDATE in cycle N+1; a queued request issues 2 cycles after the completion edge.
// Backpressure: while a sweep is in flight, one request is held in PENDING and further ones are dropped and counted in OVERRUN.
//
// Ports:
//   CLK, RST         clock and synchronous active-high reset
//   TICK, DIV        periodic timing pulse; an update is requested every DIV+1 ticks
//   FORCE_UPDATE     software request that bypasses the divider
//   SILENT_EN        requested LPF enable, latched at sweep start
//   STEP_CFG         requested LPF step, latched at sweep start
//   LPF_OUT_VALID    sweep-done level from the LPF; its rising edge marks completion
//   LPF_UPDATE       single-cycle pulse that starts one LPF sweep
//   LPF_ENABLE       latched enable driven to the LPF
//   LPF_STEP         latched step driven to the LPF
//   BUSY             sweep in flight
//   PENDING          one request queued behind the current sweep
//   OVERRUN          saturating count of dropped requests
//   ERR              sticky watchdog error
//
// Build option: define SILENT_LPF_SEQ_WATCHDOG_EN to abort sweeps that run
// for TIMEOUT cycles without completing and flag ERR. Without it ERR is tied 0.

module silent_lpf_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16,
    parameter int OVR_WIDTH = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TICK,
    input  logic [DIV_WIDTH-1:0] DIV,
    input  logic                 SILENT_EN,
    input  logic [WIDTH-1:0]     STEP_CFG,
    input  logic                 FORCE_UPDATE,
    input  logic                 LPF_OUT_VALID,
    output logic                 LPF_UPDATE,
    output logic                 LPF_ENABLE,
    output logic [WIDTH-1:0]     LPF_STEP,
    output logic                 BUSY,
    output logic                 PENDING,
    output logic [OVR_WIDTH-1:0] OVERRUN,
    output logic                 ERR
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 lpf_valid_q;
    logic                 div_req;
    logic                 req_any;
    logic                 done_edge;

    // Exact compare only: if DIV drops below div_cnt the counter runs on,
    // wraps through all-ones and matches on the way back up.
    assign div_req   = TICK && (div_cnt == DIV);
    // Divider and software request in the same cycle count as one request.
    assign req_any   = div_req | FORCE_UPDATE;
    // OUT_VALID may still be high from the previous sweep when UPDATE is
    // issued; only a fresh rising edge means this sweep finished.
    assign done_edge = LPF_OUT_VALID & ~lpf_valid_q;
    assign BUSY      = (state != S_IDLE);

`ifdef SILENT_LPF_SEQ_WATCHDOG_EN
    localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_hit;

    // wdog_cnt is 0 in the first WAIT cycle, so the abort decision is made
    // when the count is about to reach TIMEOUT-1; ERR and IDLE then appear
    // TIMEOUT cycles after the LPF_UPDATE pulse.
    assign wdog_hit = (wdog_cnt == WDOG_W'(TIMEOUT - 2));
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            lpf_valid_q <= 1'b0;
            LPF_UPDATE  <= 1'b0;
            LPF_ENABLE  <= 1'b0;
            LPF_STEP    <= '0;
            PENDING     <= 1'b0;
            OVERRUN     <= '0;
`ifdef SILENT_LPF_SEQ_WATCHDOG_EN
            wdog_cnt    <= '0;
            ERR         <= 1'b0;
`endif
        end else begin
            lpf_valid_q <= LPF_OUT_VALID;
            LPF_UPDATE  <= 1'b0;

            if (TICK) begin
                div_cnt <= div_req ? '0 : div_cnt + DIV_WIDTH'(1);
            end

            // Requests during a sweep (including the completion cycle) queue
            // one deep; anything beyond that is dropped and counted.
            if (BUSY && req_any) begin
                if (!PENDING) begin
                    PENDING <= 1'b1;
                end else if (OVERRUN != {OVR_WIDTH{1'b1}}) begin
                    OVERRUN <= OVERRUN + OVR_WIDTH'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (req_any || PENDING) begin
                        LPF_STEP   <= STEP_CFG;
                        LPF_ENABLE <= SILENT_EN;
                        // Serving a queued request while a new one arrives
                        // keeps the new one queued rather than losing it.
                        PENDING    <= PENDING & req_any;
                        LPF_UPDATE <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef SILENT_LPF_SEQ_WATCHDOG_EN
                    wdog_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (done_edge) begin
                        state <= S_IDLE;
                    end
`ifdef SILENT_LPF_SEQ_WATCHDOG_EN
                    else if (wdog_hit) begin
                        // Abort the stuck sweep; a request queued behind it
                        // is discarded, later requests are served normally.
                        state   <= S_IDLE;
                        ERR     <= 1'b1;
                        PENDING <= 1'b0;
                    end else begin
                        wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_silent_lpf_sequencer.sv
`timescale 1ns/1ps
module tb_silent_lpf_sequencer;

    localparam int WIDTH     = 8;
    localparam int DIV_WIDTH = 16;
    localparam int OVR_WIDTH = 8;
    localparam int TIMEOUT   = 16;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 TICK = 1'b0;
    logic [DIV_WIDTH-1:0] DIV = '0;
    logic                 SILENT_EN = 1'b0;
    logic [WIDTH-1:0]     STEP_CFG = '0;
    logic                 FORCE_UPDATE = 1'b0;
    logic                 LPF_OUT_VALID = 1'b0;
    logic                 LPF_UPDATE;
    logic                 LPF_ENABLE;
    logic [WIDTH-1:0]     LPF_STEP;
    logic                 BUSY;
    logic                 PENDING;
    logic [OVR_WIDTH-1:0] OVERRUN;
    logic                 ERR;

    silent_lpf_sequencer #(
        .WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .OVR_WIDTH(OVR_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .DIV(DIV), .SILENT_EN(SILENT_EN),
        .STEP_CFG(STEP_CFG), .FORCE_UPDATE(FORCE_UPDATE), .LPF_OUT_VALID(LPF_OUT_VALID),
        .LPF_UPDATE(LPF_UPDATE), .LPF_ENABLE(LPF_ENABLE), .LPF_STEP(LPF_STEP),
        .BUSY(BUSY), .PENDING(PENDING), .OVERRUN(OVERRUN), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- LPF emulation (stimulus reacting to UPDATE) ----------------
    // OUT_VALID drops the cycle after UPDATE, rises lpf_delay cycles later
    // unless lpf_hold keeps the sweep running.
    bit lpf_upd_seen = 0;
    bit lpf_busy     = 0;
    bit lpf_hold     = 0;
    int lpf_rem      = 0;
    int lpf_delay    = 1;

    always @(negedge CLK) lpf_upd_seen = (LPF_UPDATE === 1'b1);

    always @(posedge CLK) begin
        logic nv;
        nv = LPF_OUT_VALID;
        if (lpf_upd_seen) begin
            lpf_busy = 1;
            lpf_rem  = lpf_delay;
            nv       = 1'b0;
        end else if (lpf_busy) begin
            if (lpf_rem > 0) lpf_rem--;
            if (lpf_rem == 0 && !lpf_hold) begin
                nv       = 1'b1;
                lpf_busy = 0;
            end
        end
        #1 LPF_OUT_VALID = nv;
    end

    // ---------------- behavioural reference model ----------------
    // Tracks "sweep in flight", a one-deep request queue and a drop counter;
    // the divider is modelled as "every (DIV+1)-th tick since reset".
    bit         m_live = 0;
    bit         m_busy, m_pend, m_upd, m_en, m_err, m_vprev;
    int         m_ovr, tick_cnt, m_wait;
    logic [7:0] m_step;

    always @(posedge CLK) begin
        bit fire, req, edge_v, upd_now;
        if (RST) begin
            m_live = 1; m_busy = 0; m_pend = 0; m_upd = 0; m_en = 0; m_err = 0;
            m_vprev = 0; m_ovr = 0; tick_cnt = 0; m_wait = 0; m_step = 8'h00;
        end else if (m_live) begin
            fire = TICK && ((tick_cnt % (int'(DIV) + 1)) == int'(DIV));
            if (TICK) tick_cnt++;
            req     = fire || FORCE_UPDATE;
            edge_v  = LPF_OUT_VALID && !m_vprev;
            m_vprev = LPF_OUT_VALID;
            upd_now = m_upd;
            m_upd   = 0;
            if (!m_busy) begin
                if (req || m_pend) begin
                    m_busy = 1; m_upd = 1;
                    m_step = STEP_CFG; m_en = SILENT_EN;
                    m_pend = m_pend && req;
                end
            end else begin
                if (req) begin
                    if (m_pend) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                    else        m_pend = 1;
                end
                if (upd_now) begin
                    m_wait = 0;
                end else if (edge_v) begin
                    m_busy = 0;
                end
`ifdef SILENT_LPF_SEQ_WATCHDOG_EN
                else begin
                    m_wait++;
                    if (m_wait == TIMEOUT - 1) begin
                        m_busy = 0; m_err = 1; m_pend = 0;
                    end
                end
`endif
            end
        end
    end

    // Single compare process: every cycle once reset has been applied.
    always @(negedge CLK) begin
        if (m_live) begin
            chk("cyc_LPF_UPDATE", LPF_UPDATE, m_upd);
            chk("cyc_BUSY",       BUSY,       m_busy);
            chk("cyc_PENDING",    PENDING,    m_pend);
            chk("cyc_OVERRUN",    OVERRUN,    m_ovr);
            chk("cyc_LPF_STEP",   LPF_STEP,   m_step);
            chk("cyc_LPF_ENABLE", LPF_ENABLE, m_en);
            chk("cyc_ERR",        ERR,        m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic adv(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1; TICK = 0; FORCE_UPDATE = 0; lpf_hold = 0;
        adv(2);
        RST = 0;
    endtask

    int npulse;

    initial begin
        lpf_delay = 1;
        adv(1);
        do_reset();
        at_neg();
        chk("rst_UPDATE", LPF_UPDATE, 0);
        chk("rst_BUSY", BUSY, 0);
        chk("rst_OVERRUN", OVERRUN, 0);
        chk("rst_STEP", LPF_STEP, 0);
        chk("rst_ERR", ERR, 0);
        adv(1);

`ifndef SILENT_LPF_SEQ_WATCHDOG_EN
        // Basic issue: tick at cycle 10, completion edge at cycle 270.
        DIV = 0; SILENT_EN = 1; STEP_CFG = 8'h10;
        do_reset(); lpf_hold = 1;
        adv(10); TICK = 1;
        adv(1);  TICK = 0;
        at_neg();
        chk("basic_UPDATE", LPF_UPDATE, 1);
        chk("basic_STEP", LPF_STEP, 8'h10);
        chk("basic_EN", LPF_ENABLE, 1);
        chk("basic_BUSY", BUSY, 1);
        adv(258); lpf_hold = 0;
        adv(1); at_neg();
        chk("basic_BUSY_270", BUSY, 1);
        adv(1); at_neg();
        chk("basic_BUSY_271", BUSY, 0);
        adv(1);
`endif

        // Divider: DIV=3, 12 ticks, instant-completion LPF.
        DIV = 3; lpf_delay = 1;
        do_reset();
        npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            TICK = 1; adv(1); TICK = 0;
            at_neg();
            chk($sformatf("div_pulse_tick%0d", i), LPF_UPDATE, (i % 4 == 0) ? 1 : 0);
            if (LPF_UPDATE === 1'b1) npulse++;
            adv(3);
        end
        chk("div_total", npulse, 3);

        // Pending and overrun.
        DIV = 0;
        do_reset(); lpf_hold = 1;
        TICK = 1; adv(1); TICK = 0;
        adv(2);
        for (int i = 0; i < 4; i++) begin
            FORCE_UPDATE = 1; adv(1); FORCE_UPDATE = 0; adv(1);
        end
        at_neg();
        chk("ovr_PENDING", PENDING, 1);
        chk("ovr_OVERRUN", OVERRUN, 3);
        adv(1); lpf_hold = 0;
        adv(1); at_neg();
        chk("ovr_BUSY_edge", BUSY, 1);
        adv(1); at_neg();
        chk("ovr_UPDATE_e1", LPF_UPDATE, 0);
        chk("ovr_PENDING_e1", PENDING, 1);
        adv(1); at_neg();
        chk("ovr_UPDATE_e2", LPF_UPDATE, 1);
        chk("ovr_PENDING_e2", PENDING, 0);
        chk("ovr_OVERRUN_e2", OVERRUN, 3);
        adv(1);

        // Config isolation.
        SILENT_EN = 1; STEP_CFG = 8'h10;
        do_reset(); lpf_hold = 1;
        TICK = 1; adv(1); TICK = 0;
        adv(1); STEP_CFG = 8'h01; SILENT_EN = 0;
        at_neg();
        chk("cfg_STEP_wait", LPF_STEP, 8'h10);
        chk("cfg_EN_wait", LPF_ENABLE, 1);
        adv(1); lpf_hold = 0;
        adv(2); at_neg();
        chk("cfg_BUSY_idle", BUSY, 0);
        chk("cfg_STEP_idle", LPF_STEP, 8'h10);
        adv(1); TICK = 1;
        adv(1); TICK = 0;
        at_neg();
        chk("cfg_UPDATE2", LPF_UPDATE, 1);
        chk("cfg_STEP2", LPF_STEP, 8'h01);
        chk("cfg_EN2", LPF_ENABLE, 0);
        adv(1);

        // Tick in the same cycle as the completion edge.
        do_reset(); lpf_hold = 1;
        TICK = 1; adv(1); TICK = 0;
        adv(2); lpf_hold = 0;
        adv(1); TICK = 1;
        adv(1); TICK = 0;
        at_neg();
        chk("sim_PENDING", PENDING, 1);
        chk("sim_OVERRUN", OVERRUN, 0);
        chk("sim_BUSY", BUSY, 0);
        adv(1); at_neg();
        chk("sim_UPDATE", LPF_UPDATE, 1);
        adv(1);

`ifdef SILENT_LPF_SEQ_WATCHDOG_EN
        // Watchdog: LPF never completes.
        do_reset(); lpf_hold = 1;
        TICK = 1; adv(1); TICK = 0;
        at_neg();
        chk("wd_UPDATE", LPF_UPDATE, 1);
        adv(15); at_neg();
        chk("wd_ERR_15", ERR, 0);
        chk("wd_BUSY_15", BUSY, 1);
        adv(1); at_neg();
        chk("wd_ERR_16", ERR, 1);
        chk("wd_BUSY_16", BUSY, 0);
        adv(1); TICK = 1;
        adv(1); TICK = 0;
        at_neg();
        chk("wd_UPDATE2", LPF_UPDATE, 1);
        chk("wd_ERR_sticky", ERR, 1);
        adv(1); lpf_hold = 0;
        adv(4); at_neg();
        chk("wd_ERR_after", ERR, 1);
        adv(1); RST = 1;
        adv(1); RST = 0;
        at_neg();
        chk("wd_ERR_rst", ERR, 0);
        adv(1);
`endif

        // Randomized segments checked by the model every cycle.
        for (int seg = 0; seg < 6; seg++) begin
            DIV = DIV_WIDTH'($urandom_range(0, 4));
            do_reset();
            for (int c = 0; c < 300; c++) begin
                TICK         = ($urandom_range(0, 1) == 1);
                FORCE_UPDATE = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0) STEP_CFG = 8'($urandom);
                if ($urandom_range(0, 15) == 0) SILENT_EN = ($urandom_range(0, 1) == 1);
                lpf_delay = $urandom_range(1, 10);
                RST = ($urandom_range(0, 199) == 0);
                adv(1);
            end
            RST = 0; TICK = 0; FORCE_UPDATE = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
